wt_cache: RTL and testbench
===========================

WT_CACHE -- requirements
Module: wt_cache

Interface
REQ-001 Parameter ADDR_W, default 32, byte address width (>= 16).
REQ-002 Parameter LINES, default 64, number of cache lines (power of two, >= 2).
REQ-003 Parameter WORDS, default 4, 32-bit words per line (power of two, >= 1).
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 core_req_i / core_we_i / core_be_i / core_addr_i / core_wdata_i  in  1/1/4/ADDR_W/32  core request, write enable, byte enables, byte address, write data.
REQ-007 core_gnt_o / core_rvalid_o / core_rdata_o / core_error_o  out  1/1/32/1  grant, response valid, read data, response error.
REQ-008 mem_req_o / mem_we_o / mem_be_o / mem_addr_o / mem_wdata_o  out  1/1/4/ADDR_W/32  memory request channel.
REQ-009 mem_gnt_i / mem_rvalid_i / mem_rdata_i / mem_error_i  in  1/1/32/1  memory grant, response valid, read data, error (qualified by mem_rvalid_i).
REQ-010 flush_i  in  1  invalidate-all request (single-cycle pulse).
REQ-011 flush_busy_o  out  1  high while invalidation is pending or running.

Function
REQ-012 Direct-mapped, write-through, write-no-allocate. Address split: [1:0] byte, next log2(WORDS) bits word, next log2(LINES) bits index, remaining upper bits tag.
REQ-013 States: IDLE, LOOKUP, REFILL_REQ, REFILL_WAIT, WRITE_REQ, WRITE_WAIT, RESP, FLUSH.
REQ-014 core_gnt_o = core_req_i in IDLE, only when no flush is pending; otherwise 0. A request is accepted on a cycle with req&gnt; addr/we/be/wdata are captured then.
REQ-015 Accept -> LOOKUP next cycle. Hit = line valid and stored tag equals address tag.
REQ-016 Read hit: RESP in cycle after LOOKUP; core_rvalid_o high exactly one cycle, 2 cycles after accept, core_rdata_o = addressed word, core_error_o = 0.
REQ-017 Read miss: refill WORDS beats at line-aligned addresses, word 0 up to WORDS-1, mem_we_o=0, mem_be_o=4'hF; one outstanding beat at a time.
REQ-018 REFILL_REQ holds mem_req_o and address stable until mem_gnt_i; then REFILL_WAIT until mem_rvalid_i; beat data written to line word.
REQ-019 After last beat without error: line marked valid with new tag; RESP returns addressed word.
REQ-020 Refill beat with mem_error_i=1: abort remaining beats, line left invalid, RESP with core_error_o=1, core_rdata_o=0.
REQ-021 Write (hit or miss): one memory write with captured addr, wdata, be, mem_we_o=1; WRITE_REQ holds until mem_gnt_i, WRITE_WAIT until mem_rvalid_i, then RESP; core_error_o = mem_error_i of that response.
REQ-022 Write hit: bytes with be set updated in the cached word in the LOOKUP->WRITE_REQ transition; other bytes, tag, valid unchanged. Write miss: cache unchanged.
REQ-023 mem_req_o low in all states other than REFILL_REQ and WRITE_REQ; mem_wdata_o = 0 when mem_we_o = 0.
REQ-024 RESP always returns to IDLE next cycle (back-to-back accept possible in that IDLE cycle).
REQ-025 flush_i in any state sets a pending flag; pending flush enters FLUSH from IDLE before any new grant. flush_i in IDLE together with core_req_i: flush wins, no grant.
REQ-026 FLUSH clears one line valid bit per cycle, index 0 to LINES-1 (LINES cycles), then IDLE; flush_busy_o high from cycle after flush_i through last FLUSH cycle; flush_i during FLUSH ignored.

Reset
REQ-027 On reset: state IDLE, all valid bits 0, flush pending 0; all outputs 0 (core_gnt_o follows REQ-014 once reset deasserts).
REQ-028 Reset mid-transaction aborts immediately; mem_req_o drops asynchronously; no core response issued for the aborted request.

Verification (LINES=64, WORDS=4, ADDR_W=32, memory grants immediately, rvalid 1 cycle after gnt)
REQ-029 Cold read 0x0000_1008 -> 4 mem reads 0x1000,0x1004,0x1008,0x100C; rvalid once with word at 0x1008; repeat read -> rvalid 2 cycles after accept, no mem_req_o.
REQ-030 After REQ-029, write 0x0000_1008 data 0xAABBCCDD be 4'b0011 -> mem write be 0011; subsequent read hit returns old[31:16] with 0xCCDD in [15:0].
REQ-031 Read 0x0000_2008 (same index, new tag) -> refill from 0x2000; then read 0x1008 misses again.
REQ-032 Error on beat 2 of refill -> core_error_o=1 with rvalid, only 2 beats issued, re-read of same address misses.
REQ-033 flush_i pulse then core_req_i held -> flush_busy_o high 64 cycles, gnt only after, prior hit address now misses.
REQ-034 Assert reset during REFILL_WAIT -> mem_req_o 0, no rvalid, all lines invalid after release.

Source files
------------

// File: rtl/wt_cache.sv
// Direct-mapped, write-through, write-no-allocate cache between a core port and
// a single-outstanding memory port; supports a line-at-a-time invalidate-all.
module wt_cache #(
   parameter int ADDR_W = 32,
   parameter int LINES  = 64,
   parameter int WORDS  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              core_req_i,
   input  logic              core_we_i,
   input  logic [3:0]        core_be_i,
   input  logic [ADDR_W-1:0] core_addr_i,
   input  logic [31:0]       core_wdata_i,
   output logic              core_gnt_o,
   output logic              core_rvalid_o,
   output logic [31:0]       core_rdata_o,
   output logic              core_error_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [3:0]        mem_be_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [31:0]       mem_rdata_i,
   input  logic              mem_error_i,
   input  logic              flush_i,
   output logic              flush_busy_o
);
   localparam int IB      = $clog2(LINES);
   localparam int WOFF    = $clog2(WORDS);
   localparam int WB      = (WORDS > 1) ? WOFF : 1;
   localparam int TAG_LSB = 2 + WOFF + IB;
   localparam int TW      = ADDR_W - TAG_LSB;

   localparam logic [2:0] IDLE        = 3'd0;
   localparam logic [2:0] LOOKUP      = 3'd1;
   localparam logic [2:0] REFILL_REQ  = 3'd2;
   localparam logic [2:0] REFILL_WAIT = 3'd3;
   localparam logic [2:0] WRITE_REQ   = 3'd4;
   localparam logic [2:0] WRITE_WAIT  = 3'd5;
   localparam logic [2:0] RESP        = 3'd6;
   localparam logic [2:0] FLUSH       = 3'd7;

   logic [2:0]        state_q;
   logic [LINES-1:0]  valid_q;
   logic              flush_pend_q;
   logic [ADDR_W-1:0] addr_q;
   logic              we_q;
   logic [3:0]        be_q;
   logic [31:0]       wdata_q;
   logic [WB-1:0]     cnt_q;
   logic [IB-1:0]     fcnt_q;
   logic [31:0]       rdata_q;
   logic              err_q;

   logic [TW-1:0]     tag_q  [LINES];
   logic [31:0]       data_q [LINES][WORDS];

   logic [IB-1:0]     idx;
   logic [WB-1:0]     wsel;
   logic [TW-1:0]     atag;
   logic [ADDR_W-1:0] line_base;
   logic              hit;

   assign idx       = addr_q[2+WOFF +: IB];
   assign wsel      = (WORDS > 1) ? addr_q[2 +: WB] : '0;
   assign atag      = addr_q[ADDR_W-1:TAG_LSB];
   assign line_base = addr_q & ~ADDR_W'(WORDS*4 - 1);
   assign hit       = valid_q[idx] && (tag_q[idx] == atag);

   // A flush_i seen in IDLE goes straight to FLUSH, so it also blocks the grant that cycle.
   assign core_gnt_o    = core_req_i && !reset && (state_q == IDLE) && !flush_pend_q && !flush_i;
   assign core_rvalid_o = (state_q == RESP);
   assign core_rdata_o  = core_rvalid_o ? rdata_q : 32'h0;
   assign core_error_o  = core_rvalid_o && err_q;
   assign flush_busy_o  = flush_pend_q || (state_q == FLUSH);

   always_comb begin
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_be_o    = 4'h0;
      mem_addr_o  = '0;
      mem_wdata_o = 32'h0;
      if (state_q == REFILL_REQ) begin
         mem_req_o  = 1'b1;
         mem_be_o   = 4'hF;
         mem_addr_o = line_base | (ADDR_W'(cnt_q) << 2);
      end else if (state_q == WRITE_REQ) begin
         mem_req_o   = 1'b1;
         mem_we_o    = 1'b1;
         mem_be_o    = be_q;
         mem_addr_o  = addr_q;
         mem_wdata_o = wdata_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         valid_q      <= '0;
         flush_pend_q <= 1'b0;
         addr_q       <= '0;
         we_q         <= 1'b0;
         be_q         <= 4'h0;
         wdata_q      <= 32'h0;
         cnt_q        <= '0;
         fcnt_q       <= '0;
         rdata_q      <= 32'h0;
         err_q        <= 1'b0;
      end else begin
         if (flush_i && state_q != IDLE && state_q != FLUSH)
            flush_pend_q <= 1'b1;
         case (state_q)
            IDLE: begin
               if (flush_i || flush_pend_q) begin
                  flush_pend_q <= 1'b0;
                  fcnt_q       <= '0;
                  state_q      <= FLUSH;
               end else if (core_req_i) begin
                  addr_q  <= core_addr_i;
                  we_q    <= core_we_i;
                  be_q    <= core_be_i;
                  wdata_q <= core_wdata_i;
                  state_q <= LOOKUP;
               end
            end
            LOOKUP: begin
               if (we_q) begin
                  state_q <= WRITE_REQ;
               end else if (hit) begin
                  rdata_q <= data_q[idx][wsel];
                  err_q   <= 1'b0;
                  state_q <= RESP;
               end else begin
                  // Invalidate up front so an aborted refill leaves the line invalid.
                  valid_q[idx] <= 1'b0;
                  cnt_q        <= '0;
                  state_q      <= REFILL_REQ;
               end
            end
            REFILL_REQ: if (mem_gnt_i) state_q <= REFILL_WAIT;
            REFILL_WAIT: begin
               if (mem_rvalid_i) begin
                  if (mem_error_i) begin
                     rdata_q <= 32'h0;
                     err_q   <= 1'b1;
                     state_q <= RESP;
                  end else begin
                     if (cnt_q == wsel) rdata_q <= mem_rdata_i;
                     if (cnt_q == WB'(WORDS-1)) begin
                        valid_q[idx] <= 1'b1;
                        err_q        <= 1'b0;
                        state_q      <= RESP;
                     end else begin
                        cnt_q   <= cnt_q + WB'(1);
                        state_q <= REFILL_REQ;
                     end
                  end
               end
            end
            WRITE_REQ: if (mem_gnt_i) state_q <= WRITE_WAIT;
            WRITE_WAIT: begin
               if (mem_rvalid_i) begin
                  rdata_q <= 32'h0;
                  err_q   <= mem_error_i;
                  state_q <= RESP;
               end
            end
            RESP: state_q <= IDLE;
            FLUSH: begin
               valid_q[fcnt_q] <= 1'b0;
               fcnt_q          <= fcnt_q + IB'(1);
               if (fcnt_q == IB'(LINES-1)) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Tag/data arrays carry no reset; valid_q alone qualifies their contents.
   always_ff @(posedge clk) begin
      if (state_q == LOOKUP && we_q && hit) begin
         for (int b = 0; b < 4; b++)
            if (be_q[b]) data_q[idx][wsel][8*b +: 8] <= wdata_q[8*b +: 8];
      end
      if (state_q == REFILL_WAIT && mem_rvalid_i && !mem_error_i) begin
         data_q[idx][cnt_q] <= mem_rdata_i;
         tag_q[idx]         <= atag;
      end
   end
endmodule

// File: tb/tb_wt_cache.sv
// Directed bench for wt_cache: table of core transactions against a simple
// memory model, plus hand sequences for flush and mid-refill reset.
module tb_wt_cache;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        core_req_i = 1'b0, core_we_i = 1'b0;
   logic [3:0]  core_be_i = 4'h0;
   logic [31:0] core_addr_i = 32'h0, core_wdata_i = 32'h0;
   logic        core_gnt_o, core_rvalid_o, core_error_o;
   logic [31:0] core_rdata_o;
   logic        mem_req_o, mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic        mem_gnt_i, mem_rvalid_i, mem_error_i;
   logic [31:0] mem_rdata_i;
   logic        flush_i = 1'b0;
   logic        flush_busy_o;

   wt_cache #(.ADDR_W(32), .LINES(64), .WORDS(4)) dut (
      .clk(clk), .reset(reset),
      .core_req_i(core_req_i), .core_we_i(core_we_i), .core_be_i(core_be_i),
      .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
      .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o),
      .core_rdata_o(core_rdata_o), .core_error_o(core_error_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
      .mem_rdata_i(mem_rdata_i), .mem_error_i(mem_error_i),
      .flush_i(flush_i), .flush_busy_o(flush_busy_o)
   );

   always #5 clk = ~clk;

   // Memory: immediate grant, response one cycle later; unwritten words read as {D0D0, addr[15:0]}.
   logic [31:0] mem_store [logic [31:0]];
   logic [31:0] err_addr = 32'hFFFF_FFFF;
   logic        rsp_pend, rsp_err;
   logic [31:0] rsp_data;

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem_store.exists(a)) return mem_store[a];
      return {16'hD0D0, a[15:0]};
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w, input logic [3:0] be);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = w[8*b +: 8];
      return r;
   endfunction

   assign mem_gnt_i    = mem_req_o;
   assign mem_rvalid_i = rsp_pend;
   assign mem_rdata_i  = rsp_data;
   assign mem_error_i  = rsp_err;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_pend <= 1'b0;
         rsp_err  <= 1'b0;
         rsp_data <= 32'h0;
      end else begin
         rsp_pend <= mem_req_o && mem_gnt_i;
         rsp_err  <= mem_req_o && (mem_addr_o == err_addr);
         rsp_data <= (mem_req_o && !mem_we_o) ? mem_rd(mem_addr_o) : 32'h0;
         if (mem_req_o && mem_we_o)
            mem_store[mem_addr_o] = merge(mem_rd(mem_addr_o), mem_wdata_o, mem_be_o);
      end
   end

   // Monitor, sampled on the falling edge.
   int cyc = 0, mem_cnt = 0, rv_cnt = 0, busy_cnt = 0, gnt_busy = 0, wd_viol = 0;
   logic [31:0] log_addr [$];
   logic [3:0]  log_be [$];
   logic        log_we [$];
   logic [31:0] log_wd [$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (mem_req_o && mem_gnt_i) begin
         mem_cnt++;
         log_addr.push_back(mem_addr_o);
         log_be.push_back(mem_be_o);
         log_we.push_back(mem_we_o);
         log_wd.push_back(mem_wdata_o);
      end
      if (core_rvalid_o) rv_cnt++;
      if (flush_busy_o) busy_cnt++;
      if (flush_busy_o && core_gnt_o) gnt_busy++;
      if (!mem_we_o && mem_wdata_o != 32'h0) wd_viol++;
   end

   int total = 0, bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Issue one request at a falling edge and wait for its response.
   task automatic xact(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er,
                       output int lat);
      int t0, n;
      core_req_i = 1'b1; core_we_i = we; core_be_i = be;
      core_addr_i = addr; core_wdata_i = wd;
      #1;
      n = 0;
      while (!core_gnt_o && n < 200) begin @(negedge clk); #1; n++; end
      chk("gnt_wait", 32'(core_gnt_o), 32'h1);
      t0 = cyc;
      @(negedge clk);
      core_req_i = 1'b0;
      #1;
      n = 0;
      while (!core_rvalid_o && n < 200) begin @(negedge clk); #1; n++; end
      chk("rvalid_wait", 32'(core_rvalid_o), 32'h1);
      lat = cyc - t0;
      rd  = core_rdata_o;
      er  = core_error_o;
      @(negedge clk);
   endtask

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wd;
      logic [31:0] erra;
      logic [31:0] exp_rd;
      logic        exp_err;
      int          exp_lat;
      int          exp_ops;
   } vec_t;

   function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [3:0] be,
                               input logic [31:0] wd, input logic [31:0] erra,
                               input logic [31:0] exp_rd, input logic exp_err,
                               input int exp_lat, input int exp_ops);
      vec_t v;
      v.we = we; v.addr = addr; v.be = be; v.wd = wd; v.erra = erra;
      v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_lat = exp_lat; v.exp_ops = exp_ops;
      return v;
   endfunction

   localparam int NV = 13;
   localparam logic [31:0] NOE = 32'hFFFF_FFFF;
   vec_t vt [NV];

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat, m0, b0, g0, r0, n;

      //          we   addr          be    wdata         err_addr      rdata         err lat ops
      vt[0]  = mk(0, 32'h0000_1008, 4'hF, 32'h0,        NOE,          32'hD0D0_1008, 0, 10, 4);
      vt[1]  = mk(0, 32'h0000_1008, 4'hF, 32'h0,        NOE,          32'hD0D0_1008, 0,  2, 0);
      vt[2]  = mk(1, 32'h0000_1008, 4'h3, 32'hAABBCCDD, NOE,          32'h0,         0,  4, 1);
      vt[3]  = mk(0, 32'h0000_1008, 4'hF, 32'h0,        NOE,          32'hD0D0_CCDD, 0,  2, 0);
      vt[4]  = mk(0, 32'h0000_100C, 4'hF, 32'h0,        NOE,          32'hD0D0_100C, 0,  2, 0);
      vt[5]  = mk(0, 32'h0000_2008, 4'hF, 32'h0,        NOE,          32'hD0D0_2008, 0, 10, 4);
      vt[6]  = mk(0, 32'h0000_1008, 4'hF, 32'h0,        NOE,          32'hD0D0_CCDD, 0, 10, 4);
      vt[7]  = mk(1, 32'h0000_3000, 4'hF, 32'h11223344, NOE,          32'h0,         0,  4, 1);
      vt[8]  = mk(0, 32'h0000_3004, 4'hF, 32'h0,        NOE,          32'hD0D0_3004, 0, 10, 4);
      vt[9]  = mk(0, 32'h0000_3000, 4'hF, 32'h0,        NOE,          32'h11223344,  0,  2, 0);
      vt[10] = mk(0, 32'h0000_4008, 4'hF, 32'h0,        32'h0000_4004, 32'h0,        1,  6, 2);
      vt[11] = mk(0, 32'h0000_4008, 4'hF, 32'h0,        NOE,          32'hD0D0_4008, 0, 10, 4);
      vt[12] = mk(0, 32'h0000_400C, 4'hF, 32'h0,        NOE,          32'hD0D0_400C, 0,  2, 0);

      // Reset state, with a request already pending.
      core_req_i = 1'b1;
      #2;
      chk("rst_gnt",    32'(core_gnt_o),    32'h0);
      chk("rst_rvalid", 32'(core_rvalid_o), 32'h0);
      chk("rst_memreq", 32'(mem_req_o),     32'h0);
      chk("rst_busy",   32'(flush_busy_o),  32'h0);
      chk("rst_error",  32'(core_error_o),  32'h0);
      core_req_i = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < NV; i++) begin
         err_addr = vt[i].erra;
         m0 = mem_cnt;
         xact(vt[i].we, vt[i].addr, vt[i].be, vt[i].wd, rd, er, lat);
         chk($sformatf("v%0d_rdata", i), rd, vt[i].exp_rd);
         chk($sformatf("v%0d_error", i), 32'(er), 32'(vt[i].exp_err));
         chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vt[i].exp_lat));
         chk($sformatf("v%0d_memops", i), 32'(mem_cnt - m0), 32'(vt[i].exp_ops));
      end
      err_addr = NOE;

      // Refill beats of the cold read, the partial write, and the aborted refill.
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("refill_addr%0d", k), log_addr[k], 32'h0000_1000 + 32'(4*k));
         chk($sformatf("refill_be%0d", k), 32'(log_be[k]), 32'hF);
         chk($sformatf("refill_we%0d", k), 32'(log_we[k]), 32'h0);
      end
      chk("wr_we",    32'(log_we[4]), 32'h1);
      chk("wr_addr",  log_addr[4],    32'h0000_1008);
      chk("wr_be",    32'(log_be[4]), 32'h3);
      chk("wr_wdata", log_wd[4],      32'hAABBCCDD);
      chk("err_beat0_addr", log_addr[18], 32'h0000_4000);
      chk("err_beat1_addr", log_addr[19], 32'h0000_4004);

      // Flush pulse together with a held request for a line that currently hits.
      b0 = busy_cnt; g0 = gnt_busy;
      flush_i = 1'b1; core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 32'h0000_400C;
      #1;
      chk("flush_beats_gnt", 32'(core_gnt_o), 32'h0);
      @(negedge clk);
      flush_i = 1'b0;
      chk("flush_busy_rise", 32'(flush_busy_o), 32'h1);
      m0 = mem_cnt;
      xact(1'b0, 32'h0000_400C, 4'hF, 32'h0, rd, er, lat);
      chk("flush_busy_cycles", 32'(busy_cnt - b0), 32'd64);
      chk("flush_gnt_while_busy", 32'(gnt_busy - g0), 32'h0);
      chk("flush_then_miss_ops", 32'(mem_cnt - m0), 32'd4);
      chk("flush_then_miss_lat", 32'(lat), 32'd10);
      chk("flush_then_miss_rdata", rd, 32'hD0D0_400C);

      // Reset while a refill beat is outstanding.
      core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 32'h0000_5008;
      #1;
      n = 0;
      while (!core_gnt_o && n < 50) begin @(negedge clk); #1; n++; end
      chk("rst_seq_gnt", 32'(core_gnt_o), 32'h1);
      @(negedge clk);
      core_req_i = 1'b0;
      n = 0;
      while (!mem_rvalid_i && n < 50) begin @(negedge clk); n++; end
      chk("rst_seq_in_refill_wait", 32'(mem_rvalid_i), 32'h1);
      r0 = rv_cnt;
      reset = 1'b1;
      #1;
      chk("rst_seq_memreq", 32'(mem_req_o), 32'h0);
      chk("rst_seq_rvalid", 32'(core_rvalid_o), 32'h0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      chk("rst_seq_no_response", 32'(rv_cnt - r0), 32'h0);
      m0 = mem_cnt;
      xact(1'b0, 32'h0000_400C, 4'hF, 32'h0, rd, er, lat);
      chk("rst_seq_line_invalid_ops", 32'(mem_cnt - m0), 32'd4);
      chk("rst_seq_rdata", rd, 32'hD0D0_400C);

      chk("wdata_zero_on_reads", 32'(wd_viol), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
